// File: rtl/pokey_pkg.sv
// Shared POKEY constants: bus address map, SKCTL field positions, POTGO FSM states.
package pokey_pkg;

   // Address map of the pot / serial-control slots.
   localparam logic [3:0] ADDR_POT0   = 4'h0;
   localparam logic [3:0] ADDR_POT7   = 4'h7;
   localparam logic [3:0] ADDR_ALLPOT = 4'h8;
   localparam logic [3:0] ADDR_POTGO  = 4'hB;
   localparam logic [3:0] ADDR_SKCTL  = 4'hF;

   // SKCTL fields: bit 2 selects fast pot scan, [1:0]==00 holds the clock generator in init.
   localparam int SKCTL_FAST_BIT = 2;
   localparam int SKCTL_INIT_MSB = 1;
   localparam int SKCTL_INIT_LSB = 0;

   typedef enum logic [1:0] {
      PG_IDLE  = 2'd0,
      PG_ARMED = 2'd1,
      PG_PULSE = 2'd2
   } potgo_state_e;

   // True for the eight individual POTn read slots.
   function automatic logic is_pot_addr(input logic [3:0] a);
      return (a <= ADDR_POT7);
   endfunction

endpackage

// File: rtl/potgo_strobe.sv
// POTGO strobe: turns a POTGO register write into a pulse exactly one slow-clock
// period long, bounded by two enp edges. A write during the pulse queues one more.
module potgo_strobe
   import pokey_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic wr_req,
   input  logic enp,
   output logic potgo
);

   potgo_state_e state_q, state_d;
   logic         pend_q, pend_d;

   // Next-state: the bus write is considered before the enp step of the same clk.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         PG_IDLE: begin
            // A write is never consumed by an enp on its own cycle.
            if (wr_req) state_d = PG_ARMED;
         end
         PG_ARMED: begin
            // Extra writes while armed collapse into the one pending pulse.
            if (enp) state_d = PG_PULSE;
         end
         PG_PULSE: begin
            if (wr_req) pend_d = 1'b1;
            if (enp) begin
               state_d = (pend_q | wr_req) ? PG_ARMED : PG_IDLE;
               pend_d  = 1'b0;
            end
         end
         default: begin
            state_d = PG_IDLE;
            pend_d  = 1'b0;
         end
      endcase
   end

   // State register; reset drops an in-flight pulse immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PG_IDLE;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign potgo = (state_q == PG_PULSE);

endmodule

// File: rtl/pot_bus_if.sv
// CPU register interface in front of POT_core: samples bus cycles on enn,
// serves POTn/ALLPOT reads, holds SKCTL and launches POTGO scans.
module pot_bus_if
   import pokey_pkg::*;
#(
   parameter logic [3:0] ALLPOT_ADDR = ADDR_ALLPOT,
   parameter logic [3:0] POTGO_ADDR  = ADDR_POTGO,
   parameter logic [3:0] SKCTL_ADDR  = ADDR_SKCTL
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enp,
   input  logic        enn,
   input  logic        cs,
   input  logic        rw,
   input  logic [3:0]  addr,
   input  logic [7:0]  data_in,
   input  logic [63:0] pot_vals,
   input  logic [7:0]  allpot,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        POTGO,
   output logic        fastScan,
   output logic        init,
   output logic [7:0]  skctl
);

   logic       bus_samp, bus_rd, bus_wr, potgo_wr;
   logic [3:0] pot_idx;
   logic [7:0] rd_data;
   logic       rd_hit;

   logic [7:0] data_out_q, data_out_d;
   logic       data_oe_q, data_oe_d;
   logic [7:0] skctl_q, skctl_d;

   // The bus is only meaningful on the slow-clock falling-edge strobe.
   assign bus_samp = enn & cs;
   assign bus_rd   = bus_samp & rw;
   assign bus_wr   = bus_samp & ~rw;
   assign potgo_wr = bus_wr & (addr == POTGO_ADDR);
   assign pot_idx  = addr - ADDR_POT0;

   // Read mux: POTn slot, ALLPOT, or an undecoded read that floats the bus.
   always_comb begin
      rd_data = 8'h00;
      rd_hit  = 1'b0;
      if (is_pot_addr(addr)) begin
         for (int i = 0; i < 8; i++) begin
            if (pot_idx == 4'(i)) rd_data = pot_vals[i*8 +: 8];
         end
         rd_hit = 1'b1;
      end else if (addr == ALLPOT_ADDR) begin
         rd_data = allpot;
         rd_hit  = 1'b1;
      end
   end

   // Read-data and SKCTL update; read data holds until the next sampled cycle.
   always_comb begin
      data_out_d = data_out_q;
      data_oe_d  = data_oe_q;
      skctl_d    = skctl_q;
      if (bus_rd) begin
         data_out_d = rd_data;
         data_oe_d  = rd_hit;
      end
      if (bus_wr) begin
         data_oe_d = 1'b0;
         if (addr == SKCTL_ADDR) skctl_d = data_in;
      end
   end

   // Bus-side registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= 8'h00;
         data_oe_q  <= 1'b0;
         skctl_q    <= 8'h00;
      end else begin
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         skctl_q    <= skctl_d;
      end
   end

   potgo_strobe u_potgo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_req (potgo_wr),
      .enp    (enp),
      .potgo  (POTGO)
   );

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign skctl    = skctl_q;
   assign fastScan = skctl_q[SKCTL_FAST_BIT];
   assign init     = (skctl_q[SKCTL_INIT_MSB:SKCTL_INIT_LSB] == 2'b00);

endmodule

// File: tb/tb_pot_bus_if.sv
// Bench for pot_bus_if: directed scenarios with literal expectations plus a
// long randomized run, all compared every clk against a behavioural model.
module tb_pot_bus_if;

   localparam int PER = 28;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enp = 1'b0, enn = 1'b0;
   logic        cs = 1'b0, rw = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [7:0]  data_in = 8'h00;
   logic [63:0] pot_vals = 64'h0;
   logic [7:0]  allpot = 8'h00;
   logic [7:0]  data_out;
   logic        data_oe, POTGO, fastScan, init;
   logic [7:0]  skctl;

   int  n_cmp = 0, n_bad = 0;
   int  ph = 0;
   bit  glitch = 1'b0;
   bit  chk_on = 1'b0;
   logic [7:0] pv [8];

   pot_bus_if dut (
      .clk(clk), .rst_n(rst_n), .enp(enp), .enn(enn), .cs(cs), .rw(rw),
      .addr(addr), .data_in(data_in), .pot_vals(pot_vals), .allpot(allpot),
      .data_out(data_out), .data_oe(data_oe), .POTGO(POTGO),
      .fastScan(fastScan), .init(init), .skctl(skctl)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Slow-clock strobes: enp at phase 0, enn at mid-period; glitch adds enn on the enp cycle.
   initial begin
      forever begin
         @(posedge clk); #2;
         ph  = (ph == PER-1) ? 0 : ph + 1;
         enp = (ph == 0);
         enn = (ph == PER/2) || (glitch && ph == 0);
      end
   end

   // Behavioural model: a pulse is "owed" after a POTGO write and is paid out on the
   // next enp while the line is low; a pulse always lasts one enp-to-enp interval.
   logic [7:0] m_skctl = 8'h00, m_dout = 8'h00;
   logic       m_oe = 1'b0, m_high = 1'b0, m_owed = 1'b0;

   always @(posedge clk or negedge rst_n) begin : model
      logic samp, wb, owed_now;
      if (!rst_n) begin
         m_skctl <= 8'h00; m_dout <= 8'h00; m_oe <= 1'b0;
         m_high  <= 1'b0;  m_owed <= 1'b0;
      end else begin
         samp = enn && cs;
         if (samp && rw) begin
            if (addr < 4'd8)       begin m_dout <= pv[addr[2:0]]; m_oe <= 1'b1; end
            else if (addr == 4'h8) begin m_dout <= allpot;        m_oe <= 1'b1; end
            else                   begin m_dout <= 8'h00;         m_oe <= 1'b0; end
         end
         if (samp && !rw) begin
            m_oe <= 1'b0;
            if (addr == 4'hF) m_skctl <= data_in;
         end
         wb       = samp && !rw && (addr == 4'hB);
         owed_now = m_owed || wb;
         if (enp && m_high)      begin m_high <= 1'b0; m_owed <= owed_now; end
         else if (enp && m_owed) begin m_high <= 1'b1; m_owed <= 1'b0;     end
         else                          m_owed <= owed_now;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("data_out", data_out, m_dout);
         chk("data_oe",  data_oe,  m_oe);
         chk("POTGO",    POTGO,    m_high);
         chk("skctl",    skctl,    m_skctl);
         chk("fastScan", fastScan, m_skctl[2]);
         chk("init",     init,     (m_skctl[1:0] == 2'b00));
      end
   end

   task automatic set_pots();
      for (int i = 0; i < 8; i++) pot_vals[i*8 +: 8] = pv[i];
   endtask

   // One bus cycle, presented so that the next enn-qualified edge samples it.
   task automatic bus(input logic r, input logic [3:0] a, input logic [7:0] d);
      bit got = 1'b0;
      for (int n = 0; n < 4*PER && !got; n++) begin
         @(posedge clk); #5;
         got = enn;
      end
      chk("bus_enn_seen", got, 1'b1);
      cs = 1'b1; rw = r; addr = a; data_in = d;
      @(posedge clk); #5;
      cs = 1'b0; rw = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      bit got = 1'b0;
      for (int n = 0; n < 2*PER && !got; n++) begin
         @(posedge clk); #5;
         got = (ph == p);
      end
      chk("phase_seen", got, 1'b1);
   endtask

   task automatic wait_potgo();
      bit got = 1'b0;
      for (int n = 0; n < 4*PER && !got; n++) begin
         @(posedge clk); #5;
         got = POTGO;
      end
      chk("potgo_rise_seen", got, 1'b1);
   endtask

   // Observe POTGO for w cycles: rising edges, length of last completed high run,
   // and length of the low run preceding the last rise.
   task automatic measure(input int w, output int rises, output int last_hi, output int gap);
      logic prev, cur;
      int   hi_run, lo_run;
      prev = POTGO; rises = 0; last_hi = 0; gap = -1;
      hi_run = POTGO ? 1 : 0;
      lo_run = POTGO ? 0 : 1;
      for (int n = 0; n < w; n++) begin
         @(posedge clk); #5;
         cur = POTGO;
         if (cur && !prev) begin rises++; gap = lo_run; hi_run = 0; end
         if (!cur && prev) begin last_hi = hi_run; lo_run = 0; end
         if (cur) hi_run++; else lo_run++;
         prev = cur;
      end
   endtask

   initial begin
      int rises, width, gap, sel;
      for (int i = 0; i < 8; i++) pv[i] = 8'h00;
      set_pots();
      #3 rst_n = 1'b0;
      chk_on = 1'b1;
      repeat (4) @(posedge clk);
      #5;
      chk("rst_skctl",    skctl,    8'h00);
      chk("rst_init",     init,     1'b1);
      chk("rst_fastScan", fastScan, 1'b0);
      chk("rst_POTGO",    POTGO,    1'b0);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_data_oe",  data_oe,  1'b0);
      rst_n = 1'b1;

      // SKCTL writes
      bus(1'b0, 4'hF, 8'h03);
      chk("skctl_03", skctl, 8'h03);
      chk("init_03",  init,  1'b0);
      chk("fast_03",  fastScan, 1'b0);
      bus(1'b0, 4'hF, 8'h07);
      chk("skctl_07", skctl, 8'h07);
      chk("fast_07",  fastScan, 1'b1);

      // Single POTGO pulse
      bus(1'b0, 4'hB, 8'h5A);
      measure(5*PER, rises, width, gap);
      chk("single_rises", rises, 1);
      chk("single_width", width, PER);

      // Re-trigger during the pulse: second pulse one low period later
      bus(1'b0, 4'hB, 8'h00);
      wait_potgo();
      bus(1'b0, 4'hB, 8'h00);
      measure(5*PER, rises, width, gap);
      chk("retrig_rises", rises, 1);
      chk("retrig_gap",   gap,   PER);
      chk("retrig_width", width, PER);

      // Two writes while armed; the second coincides with enp and is absorbed
      glitch = 1'b1;
      wait_phase(4);
      bus(1'b0, 4'hB, 8'h00);
      bus(1'b0, 4'hB, 8'h00);
      chk("armed_potgo_up", POTGO, 1'b1);
      measure(5*PER, rises, width, gap);
      chk("armed_rises", rises, 0);
      chk("armed_width", width, PER);

      // Write from idle on an enp+enn cycle fires only at the following enp
      wait_phase(20);
      bus(1'b0, 4'hB, 8'h00);
      measure(4*PER, rises, width, gap);
      chk("glitch_rises", rises, 1);
      chk("glitch_delay", gap,   PER);
      chk("glitch_width", width, PER);
      glitch = 1'b0;

      // Reads
      for (int i = 0; i < 8; i++) pv[i] = 8'(8'h11 * i);
      set_pots();
      allpot = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         bus(1'b1, 4'(i), 8'h00);
         chk("rd_pot",    data_out, 8'(8'h11 * i));
         chk("rd_pot_oe", data_oe,  1'b1);
      end
      bus(1'b1, 4'h8, 8'h00);
      chk("rd_allpot",    data_out, 8'hA5);
      chk("rd_allpot_oe", data_oe,  1'b1);
      bus(1'b1, 4'hC, 8'h00);
      chk("rd_unmapped",    data_out, 8'h00);
      chk("rd_unmapped_oe", data_oe,  1'b0);
      bus(1'b1, 4'h3, 8'h00);
      bus(1'b0, 4'h2, 8'hFF);
      chk("wr_clears_oe",  data_oe,  1'b0);
      chk("wr_keeps_data", data_out, 8'h33);
      chk("wr_unmapped",   skctl,    8'h07);

      // Reset in the middle of a pulse
      bus(1'b0, 4'hB, 8'h00);
      wait_potgo();
      repeat (5) @(posedge clk);
      #5 rst_n = 1'b0;
      #1;
      chk("rst_async_POTGO", POTGO, 1'b0);
      #10000;
      chk("rst_mid_skctl", skctl, 8'h00);
      chk("rst_mid_init",  init,  1'b1);
      rst_n = 1'b1;
      bus(1'b0, 4'hB, 8'h00);
      measure(5*PER, rises, width, gap);
      chk("post_rst_rises", rises, 1);
      chk("post_rst_width", width, PER);

      // Randomized traffic, including undecoded cycles and enn/enp coincidences
      repeat (15000) begin
         @(posedge clk); #5;
         if ($urandom_range(0, 199) == 0) glitch = ~glitch;
         cs  = ($urandom_range(0, 2) != 0);
         rw  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         addr = (sel < 3) ? 4'hB : (sel < 5) ? 4'hF : 4'($urandom_range(0, 15));
         data_in = 8'($urandom);
         if (sel == 3) data_in[1:0] = 2'b00;
         if ($urandom_range(0, 99) == 0) begin
            for (int i = 0; i < 8; i++) pv[i] = 8'($urandom);
            set_pots();
            allpot = 8'($urandom);
         end
      end
      cs = 1'b0;
      repeat (4) @(posedge clk);
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, compared %0d, expected completion", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
